// File: rtl/bp_common_pkg.sv
// Shared LCE response parameters and small helpers.
// Provides the credit-count width macro used by the LCE response block.
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x)+1))
`endif

package bp_common_pkg;

  localparam int lce_resp_width_gp = 64;

  // Operand is always below 2*n, so one subtract replaces a modulo.
  function automatic int wrap_f(input int a, input int n);
    if (a >= n) return a - n;
    return a;
  endfunction

endpackage

// File: rtl/bp_lce_credit_counter.sv
// Outstanding-request credit counter with multi-strobe return.
// Clamps at zero on underflow and latches a sticky error.
module bp_lce_credit_counter
  import bp_common_pkg::*;
#(
  parameter int max_credits_p = 8,
  parameter int num_ret_p     = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                inc_i,
  input  logic [num_ret_p-1:0]                ret_i,
  output logic [`BSG_WIDTH(max_credits_p)-1:0] count_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic                                error_o
);

  localparam int cw_lp = `BSG_WIDTH(max_credits_p);

  logic [cw_lp-1:0] count_r;
  logic [cw_lp-1:0] count_n;
  logic             error_r;
  logic             under;
  int               dec;
  int               sum;

  always_comb begin
    dec = 0;
    for (int i = 0; i < num_ret_p; i++) begin
      dec = dec + (ret_i[i] ? 1 : 0);
    end
    sum     = int'(count_r) + (inc_i ? 1 : 0) - dec;
    under   = (sum < 0);
    count_n = under ? '0 : cw_lp'(sum);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
      error_r <= 1'b0;
    end else begin
      count_r <= count_n;
      error_r <= error_r | under;
    end
  end

  assign count_o = count_r;
  assign full_o  = (count_r == cw_lp'(max_credits_p));
  assign empty_o = (count_r == '0);
  assign error_o = error_r;

endmodule

// File: rtl/bp_lce_resp_credit_arb.sv
// N-way LCE response arbiter with grant lock and request credits.
// Fixed-priority or round-robin; grant holds while backpressured.
module bp_lce_resp_credit_arb
  import bp_common_pkg::*;
#(
  parameter int num_src_p     = 2,
  parameter int resp_width_p  = lce_resp_width_gp,
  parameter int rr_mode_p     = 0,
  parameter int max_credits_p = 8,
  parameter int num_ret_p     = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_src_p*resp_width_p-1:0]   src_resp_i,
  input  logic [num_src_p-1:0]                src_v_i,
  output logic [num_src_p-1:0]                src_yumi_o,
  output logic [resp_width_p-1:0]             lce_resp_o,
  output logic                                lce_resp_v_o,
  input  logic                                lce_resp_ready_i,
  input  logic                                lce_req_v_i,
  input  logic                                lce_req_ready_i,
  output logic                                lce_req_ready_o,
  input  logic [num_ret_p-1:0]                credit_return_i,
  output logic [`BSG_WIDTH(max_credits_p)-1:0] credit_count_o,
  output logic                                credits_full_o,
  output logic                                credits_empty_o,
  output logic                                credit_error_o
);

  localparam int ptr_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  logic [ptr_w_lp-1:0] rr_ptr_r;
  logic [ptr_w_lp-1:0] lock_idx_r;
  logic [ptr_w_lp-1:0] pick;
  logic [ptr_w_lp-1:0] grant;
  logic [ptr_w_lp-1:0] ptr_next;
  logic                lock_r;
  logic                pick_v;
  logic                resp_v;
  logic                hs;
  logic                inc;
  int                  j;

  // Last match wins, so scan from the far end toward the start.
  always_comb begin
    pick   = '0;
    pick_v = 1'b0;
    j      = 0;
    for (int k = num_src_p - 1; k >= 0; k--) begin
      j = (rr_mode_p != 0) ? wrap_f(int'(rr_ptr_r) + k, num_src_p) : k;
      if (src_v_i[j]) begin
        pick   = ptr_w_lp'(j);
        pick_v = 1'b1;
      end
    end
  end

  assign grant  = lock_r ? lock_idx_r : pick;
  assign resp_v = lock_r ? src_v_i[lock_idx_r] : pick_v;

  assign lce_resp_v_o = reset_n_i & resp_v;
  assign hs           = lce_resp_v_o & lce_resp_ready_i;
  assign lce_resp_o   = src_resp_i[int'(grant)*resp_width_p +: resp_width_p];

  always_comb begin
    src_yumi_o = '0;
    if (hs) src_yumi_o[grant] = 1'b1;
  end

  assign ptr_next = ptr_w_lp'(wrap_f(int'(grant) + 1, num_src_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r   <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (hs) begin
      lock_r <= 1'b0;
      if (rr_mode_p != 0) rr_ptr_r <= ptr_next;
    end else if (lce_resp_v_o) begin
      lock_r     <= 1'b1;
      lock_idx_r <= grant;
    end
  end

  assign lce_req_ready_o = reset_n_i & lce_req_ready_i & ~credits_full_o;
  assign inc             = lce_req_v_i & lce_req_ready_o;

  bp_lce_credit_counter #(
    .max_credits_p(max_credits_p),
    .num_ret_p    (num_ret_p)
  ) credit_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (inc),
    .ret_i    (credit_return_i),
    .count_o  (credit_count_o),
    .full_o   (credits_full_o),
    .empty_o  (credits_empty_o),
    .error_o  (credit_error_o)
  );

endmodule

// File: tb/tb_bp_lce_resp_credit_arb.sv
// Bench for the LCE response arbiter: fixed 2-source and RR 3-source
// instances, directed scenarios then randomized traffic vs a model.
module tb_bp_lce_resp_credit_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] fd [2];
  logic [63:0] rd [3];
  logic [127:0] f_resp;
  logic [191:0] r_resp;
  assign f_resp = {fd[1], fd[0]};
  assign r_resp = {rd[2], rd[1], rd[0]};

  logic [1:0]  fv, f_yumi;
  logic [2:0]  rv, r_yumi;
  logic [63:0] f_out, r_out;
  logic        f_v, r_v, f_rdy, r_rdy;
  logic        req_v, req_rdy;
  logic [3:0]  ret;
  logic        f_qr, r_qr;
  logic [3:0]  f_cnt, r_cnt;
  logic        f_full, r_full, f_empty, r_empty, f_err, r_err;

  bp_lce_resp_credit_arb #(
    .num_src_p(2), .resp_width_p(64), .rr_mode_p(0),
    .max_credits_p(8), .num_ret_p(4)
  ) dut_f (
    .clk_i(clk), .reset_n_i(rst_n),
    .src_resp_i(f_resp), .src_v_i(fv), .src_yumi_o(f_yumi),
    .lce_resp_o(f_out), .lce_resp_v_o(f_v), .lce_resp_ready_i(f_rdy),
    .lce_req_v_i(req_v), .lce_req_ready_i(req_rdy),
    .lce_req_ready_o(f_qr), .credit_return_i(ret),
    .credit_count_o(f_cnt), .credits_full_o(f_full),
    .credits_empty_o(f_empty), .credit_error_o(f_err)
  );

  bp_lce_resp_credit_arb #(
    .num_src_p(3), .resp_width_p(64), .rr_mode_p(1),
    .max_credits_p(8), .num_ret_p(4)
  ) dut_r (
    .clk_i(clk), .reset_n_i(rst_n),
    .src_resp_i(r_resp), .src_v_i(rv), .src_yumi_o(r_yumi),
    .lce_resp_o(r_out), .lce_resp_v_o(r_v), .lce_resp_ready_i(r_rdy),
    .lce_req_v_i(req_v), .lce_req_ready_i(req_rdy),
    .lce_req_ready_o(r_qr), .credit_return_i(ret),
    .credit_count_o(r_cnt), .credits_full_o(r_full),
    .credits_empty_o(r_empty), .credit_error_o(r_err)
  );

  int checks = 0;
  int failures = 0;

  int m_cnt;
  bit m_err;
  bit f_lock, r_lock;
  int f_lidx, r_lidx, r_ptr;
  logic [1:0] f_hs;
  logic [2:0] r_hs;

  logic [1:0]  o_fy;
  logic [2:0]  o_ry;
  logic [63:0] o_fout;
  logic [3:0]  o_fcnt;
  logic        o_ferr, o_fqr, o_ffull, o_fempty;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_err = 0;
    f_lock = 0; f_lidx = 0;
    r_lock = 0; r_lidx = 0; r_ptr = 0;
    f_hs = '0; r_hs = '0;
  endtask

  function automatic void arb_exp(input int n, input logic [2:0] v,
      input bit rr, input int ptr, input bit lk, input int li,
      output int g, output bit ev);
    g = 0; ev = 0;
    if (lk) begin
      g = li; ev = v[li];
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = rr ? (ptr + k) % n : k;
        if (!ev && v[i]) begin g = i; ev = 1; end
      end
    end
  endfunction

  task automatic cycle();
    int fg, rg, nx;
    bit fe, re, qr;
    logic [2:0] fy, ry;
    @(negedge clk);
    arb_exp(2, {1'b0, fv}, 0, 0, f_lock, f_lidx, fg, fe);
    arb_exp(3, rv, 1, r_ptr, r_lock, r_lidx, rg, re);
    fy = (fe && f_rdy) ? (3'b001 << fg) : 3'b000;
    ry = (re && r_rdy) ? (3'b001 << rg) : 3'b000;
    qr = req_rdy && (m_cnt != 8);
    chk("f_resp_v", f_v, fe);
    if (fe) chk("f_resp", f_out, fd[fg]);
    chk("f_yumi", f_yumi, fy);
    chk("r_resp_v", r_v, re);
    if (re) chk("r_resp", r_out, rd[rg]);
    chk("r_yumi", r_yumi, ry);
    chk("f_req_rdy", f_qr, qr);
    chk("f_count", f_cnt, m_cnt);
    chk("f_full", f_full, m_cnt == 8);
    chk("f_empty", f_empty, m_cnt == 0);
    chk("f_err", f_err, m_err);
    chk("r_req_rdy", r_qr, qr);
    chk("r_count", r_cnt, m_cnt);
    chk("r_err", r_err, m_err);
    o_fy = f_yumi; o_ry = r_yumi; o_fout = f_out;
    o_fcnt = f_cnt; o_ferr = f_err; o_fqr = f_qr;
    o_ffull = f_full; o_fempty = f_empty;
    @(posedge clk);
    if (fe && f_rdy) f_lock = 0;
    else if (fe) begin f_lock = 1; f_lidx = fg; end
    if (re && r_rdy) begin r_lock = 0; r_ptr = (rg + 1) % 3; end
    else if (re) begin r_lock = 1; r_lidx = rg; end
    nx = m_cnt + ((req_v && qr) ? 1 : 0) - $countones(ret);
    if (nx < 0) begin nx = 0; m_err = 1; end
    m_cnt = nx;
    f_hs = fy[1:0]; r_hs = ry;
    #1;
  endtask

  logic [2:0] rr_exp [5];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rst_n = 1'b0;
    fv = '0; rv = '0; f_rdy = 0; r_rdy = 0;
    req_v = 0; req_rdy = 0; ret = '0;
    for (int i = 0; i < 2; i++) fd[i] = '0;
    for (int i = 0; i < 3; i++) rd[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cycle();
    chk("rst_count", o_fcnt, 0);
    chk("rst_empty", o_fempty, 1);
    chk("rst_err", o_ferr, 0);
    chk("rst_yumi", o_fy, 0);

    // round-robin sweep with everyone valid
    for (int i = 0; i < 3; i++) rd[i] = {$urandom, $urandom};
    rv = 3'b111; r_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_grant", o_ry, rr_exp[i]);
    end
    rv = '0; r_rdy = 0;

    // lock holds src1 against a later src0 arrival
    fd[1] = 64'hA1A1_0000_1111_2222;
    fv = 2'b10; f_rdy = 0;
    repeat (3) begin
      cycle();
      chk("lock_hold", o_fout, 64'hA1A1_0000_1111_2222);
    end
    fd[0] = 64'hB0B0_3333_4444_5555;
    fv = 2'b11;
    cycle();
    chk("lock_vs_src0", o_fout, 64'hA1A1_0000_1111_2222);
    f_rdy = 1;
    cycle();
    chk("lock_yumi", o_fy, 2'b10);
    fv = 2'b01;
    cycle();
    chk("after_lock_yumi", o_fy, 2'b01);
    chk("after_lock_data", o_fout, 64'hB0B0_3333_4444_5555);
    fv = '0; f_rdy = 0;

    // fill credits
    req_v = 1; req_rdy = 1;
    repeat (8) cycle();
    ret = 4'b0001;
    cycle();
    chk("fill_count", o_fcnt, 8);
    chk("fill_full", o_ffull, 1);
    chk("fill_ready", o_fqr, 0);
    ret = '0; req_v = 0;
    cycle();
    chk("ret_count", o_fcnt, 7);
    chk("ret_ready", o_fqr, 1);

    // simultaneous inc and multi-return
    ret = 4'b1111;
    cycle();
    ret = 4'b1011; req_v = 1;
    cycle();
    chk("sim_pre", o_fcnt, 3);
    ret = '0; req_v = 0;
    cycle();
    chk("sim_count", o_fcnt, 1);

    // underflow
    ret = 4'b0011;
    cycle();
    ret = '0;
    cycle();
    chk("uf_count", o_fcnt, 0);
    chk("uf_err", o_ferr, 1);
    req_v = 1;
    repeat (5) cycle();
    req_v = 0;
    cycle();
    chk("uf_count5", o_fcnt, 5);
    chk("uf_sticky", o_ferr, 1);

    // asynchronous reset mid-traffic
    fv = 2'b11; rv = 3'b011; f_rdy = 0; r_rdy = 0;
    req_v = 1; req_rdy = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_f_v", f_v, 0);
    chk("ar_r_v", r_v, 0);
    chk("ar_f_yumi", f_yumi, 0);
    chk("ar_req_rdy", f_qr, 0);
    chk("ar_count", f_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fv = '0; rv = '0; req_v = 0;
    cycle();
    chk("ar_post_count", o_fcnt, 0);
    chk("ar_post_err", o_ferr, 0);

    // randomized legal traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (f_hs[i]) fv[i] = 1'b0;
        if (!fv[i] && $urandom_range(0, 2) == 0) begin
          fv[i] = 1'b1; fd[i] = {$urandom, $urandom};
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (r_hs[i]) rv[i] = 1'b0;
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1; rd[i] = {$urandom, $urandom};
        end
      end
      f_rdy = ($urandom_range(0, 3) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      req_v = $urandom_range(0, 1) == 1;
      req_rdy = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 4; b++) ret[b] = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
